// File: rtl/regfile_write_arbiter.sv
// Four-requester round-robin arbiter for the register-file byte-write port,
// with burst locking and a single registered write stage under valid/stall control.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned REG_CNT   = 8,
  localparam int unsigned ADDR_W    = 5,
  localparam int unsigned REG_IDX_W = 3,
  localparam int unsigned PTR_W     = 2,
  localparam int unsigned LANES     = 4,
  localparam int unsigned WORD_W    = LANES * BYTE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_valid,
  input  logic                      wr_stall,
  output logic [REG_CNT-1:0]        wr_reg_en,
  output logic [LANES-1:0]          wr_byte_en,
  output logic [WORD_W-1:0]         wr_data,
  output logic [PTR_W-1:0]          wr_src
);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  cand;
  logic              gnt_any;
  logic              can_accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [BYTE_W-1:0] sel_data;
  logic              sel_last;

  // The stage can take a new write when it is empty or draining this cycle.
  assign can_accept = !wr_valid || !wr_stall;

  // Grant selection: owner only while locked, otherwise first valid from ptr upward.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!rst && can_accept) begin
      if (state == LOCKED) begin
        gnt_any = req_valid[owner];
        gnt_idx = owner;
      end else begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          cand = ptr + PTR_W'(k);
          if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign sel_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[gnt_idx*BYTE_W +: BYTE_W];
  assign sel_last = req_last[gnt_idx];

  // Arbitration state and write stage; a stalled full stage holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      ptr        <= '0;
      owner      <= '0;
      wr_valid   <= 1'b0;
      wr_reg_en  <= '0;
      wr_byte_en <= '0;
      wr_data    <= '0;
      wr_src     <= '0;
    end else begin
      if (gnt_any) begin
        if (sel_last) begin
          state <= ARB;
          ptr   <= gnt_idx + PTR_W'(1);
        end else begin
          state <= LOCKED;
          owner <= gnt_idx;
        end
        wr_valid   <= 1'b1;
        wr_reg_en  <= REG_CNT'(1) << sel_addr[REG_IDX_W-1:0];
        wr_byte_en <= LANES'(1) << sel_addr[ADDR_W-1:REG_IDX_W];
        wr_data    <= {LANES{sel_data}};
        wr_src     <= gnt_idx;
      end else if (!wr_valid || !wr_stall) begin
        wr_valid   <= 1'b0;
        wr_reg_en  <= '0;
        wr_byte_en <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration and write-stage rules.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wr_valid;
  logic        wr_stall;
  logic [7:0]  wr_reg_en;
  logic [3:0]  wr_byte_en;
  logic [31:0] wr_data;
  logic [1:0]  wr_src;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_ptr    = 0;
  int          m_owner  = 0;
  bit          m_locked = 0;
  bit          m_valid  = 0;
  logic [7:0]  m_reg    = '0;
  logic [3:0]  m_byte   = '0;
  logic [31:0] m_data   = '0;
  logic [1:0]  m_src    = '0;

  regfile_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_valid  (wr_valid),
    .wr_stall  (wr_stall),
    .wr_reg_en (wr_reg_en),
    .wr_byte_en(wr_byte_en),
    .wr_data   (wr_data),
    .wr_src    (wr_src)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Which requester the rules say gets the port this cycle, -1 for none.
  function automatic int exp_grant();
    if (rst) return -1;
    if (m_valid && wr_stall) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < 4; k++) begin
      if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic set_req(input int i, input logic [4:0] a, input logic [7:0] d, input logic l);
    req_addr[i*5 +: 5] = a;
    req_data[i*8 +: 8] = d;
    req_last[i]        = l;
  endtask

  // Advance one clock and move the model along with it.
  task automatic tick();
    int g;
    logic [4:0] a;
    g = exp_grant();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_owner = 0; m_locked = 0;
      m_valid = 0; m_reg = '0; m_byte = '0; m_data = '0; m_src = '0;
    end else if (g >= 0) begin
      a       = req_addr[g*5 +: 5];
      m_valid = 1;
      m_reg   = 8'(1 << (a % 8));
      m_byte  = 4'(1 << (a / 8));
      m_data  = 32'(req_data[g*8 +: 8]) * 32'h0101_0101;
      m_src   = 2'(g);
      if (req_last[g]) begin
        m_locked = 0;
        m_ptr    = (g + 1) % 4;
      end else begin
        m_locked = 1;
        m_owner  = g;
      end
    end else if (!(m_valid && wr_stall)) begin
      m_valid = 0; m_reg = '0; m_byte = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    wr_stall = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_stall = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i), 8'(i), 1'b1);
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    tick();
    rst = 1'b0;
    req_valid = '0;
    #1;
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got=%b want=0", wr_valid); end
    total++; if (wr_reg_en !== 8'h00 || wr_byte_en !== 4'h0) begin bad++; $display("FAIL reset_enables got=%h/%h want=00/0", wr_reg_en, wr_byte_en); end
    total++; if (wr_data !== 32'h0 || wr_src !== 2'd0) begin bad++; $display("FAIL reset_data_src got=%h/%0d want=0/0", wr_data, wr_src); end
  endtask

  task automatic test_single_write();
    set_req(0, 5'b10_011, 8'hA5, 1'b1);
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    total++; if (wr_valid !== 1'b1 || wr_src !== 2'd0) begin bad++; $display("FAIL single_valid_src got=%b/%0d want=1/0", wr_valid, wr_src); end
    total++; if (wr_reg_en !== 8'h08 || wr_byte_en !== 4'h4) begin bad++; $display("FAIL single_enables got=%h/%h want=08/4", wr_reg_en, wr_byte_en); end
    total++; if (wr_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL single_data got=%h want=a5a5a5a5", wr_data); end
    tick();
    #1;
    total++; if (wr_valid !== 1'b0 || wr_reg_en !== 8'h00 || wr_byte_en !== 4'h0) begin bad++; $display("FAIL single_drain got=%b/%h/%h want=0/00/0", wr_valid, wr_reg_en, wr_byte_en); end
    total++; if (wr_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL single_data_hold got=%h want=a5a5a5a5", wr_data); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 5'(i * 9), 8'(8'h10 + i), 1'b1);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (req_ready !== 4'(1 << (c % 4))) begin bad++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, req_ready, 4'(1 << (c % 4))); end
      if (c > 0) begin
        total++; if (wr_valid !== 1'b1 || wr_src !== 2'((c - 1) % 4)) begin bad++; $display("FAIL rr_src c=%0d got=%b/%0d want=1/%0d", c, wr_valid, wr_src, (c - 1) % 4); end
      end
      tick();
    end
    req_valid = '0;
    #1;
    total++; if (wr_src !== 2'd3) begin bad++; $display("FAIL rr_src_last got=%0d want=3", wr_src); end
    tick();
  endtask

  task automatic test_stall();
    set_req(0, 5'b01_101, 8'h3C, 1'b1);
    req_valid = 4'b0001;
    #1;
    tick();
    wr_stall = 1'b1;
    set_req(1, 5'b11_000, 8'hC3, 1'b1);
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL stall_ready c=%0d got=%b want=0000", c, req_ready); end
      total++; if (wr_valid !== 1'b1 || wr_reg_en !== 8'h20 || wr_byte_en !== 4'h2 || wr_data !== 32'h3C3C_3C3C || wr_src !== 2'd0) begin
        bad++; $display("FAIL stall_hold c=%0d got=%b/%h/%h/%h/%0d want=1/20/2/3c3c3c3c/0", c, wr_valid, wr_reg_en, wr_byte_en, wr_data, wr_src);
      end
      tick();
    end
    wr_stall = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL stall_release_ready got=%b want=0010", req_ready); end
    tick();
    req_valid = '0;
    #1;
    total++; if (wr_valid !== 1'b1 || wr_src !== 2'd1 || wr_reg_en !== 8'h01 || wr_byte_en !== 4'h8 || wr_data !== 32'hC3C3_C3C3) begin
      bad++; $display("FAIL stall_reload got=%b/%0d/%h/%h/%h want=1/1/01/8/c3c3c3c3", wr_valid, wr_src, wr_reg_en, wr_byte_en, wr_data);
    end
    tick();
  endtask

  task automatic test_burst_lock();
    do_reset();
    set_req(1, 5'b00_000, 8'h11, 1'b1);
    req_valid = 4'b0010;
    #1;
    tick();
    set_req(0, 5'b00_100, 8'h01, 1'b1);
    set_req(1, 5'b00_101, 8'h02, 1'b1);
    set_req(2, 5'b00_010, 8'hB0, 1'b0);
    req_valid = 4'b0111;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL burst_beat0 got=%b want=0100", req_ready); end
    tick();
    set_req(2, 5'b01_010, 8'hB1, 1'b0);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL burst_beat1 got=%b want=0100", req_ready); end
    total++; if (wr_src !== 2'd2 || wr_data !== 32'hB0B0_B0B0) begin bad++; $display("FAIL burst_out0 got=%0d/%h want=2/b0b0b0b0", wr_src, wr_data); end
    tick();
    req_valid = 4'b0011;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL burst_bubble got=%b want=0000", req_ready); end
    total++; if (wr_data !== 32'hB1B1_B1B1 || wr_byte_en !== 4'h2) begin bad++; $display("FAIL burst_out1 got=%h/%h want=b1b1b1b1/2", wr_data, wr_byte_en); end
    tick();
    set_req(2, 5'b10_010, 8'hB2, 1'b1);
    req_valid = 4'b0111;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL burst_beat2 got=%b want=0100", req_ready); end
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL burst_gap got=%b want=0", wr_valid); end
    tick();
    req_valid = 4'b0011;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL burst_next_grant got=%b want=0001", req_ready); end
    total++; if (wr_data !== 32'hB2B2_B2B2 || wr_byte_en !== 4'h4 || wr_src !== 2'd2) begin bad++; $display("FAIL burst_out2 got=%h/%h/%0d want=b2b2b2b2/4/2", wr_data, wr_byte_en, wr_src); end
    tick();
    req_valid = '0;
    #1;
    total++; if (wr_src !== 2'd0) begin bad++; $display("FAIL burst_after_src got=%0d want=0", wr_src); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(1, 5'b00_001, 8'h77, 1'b0);
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rstb_beat0 got=%b want=0010", req_ready); end
    tick();
    rst = 1'b1;
    set_req(0, 5'b00_110, 8'h66, 1'b1);
    set_req(1, 5'b00_001, 8'h78, 1'b0);
    req_valid = 4'b0011;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rstb_ready_in_reset got=%b want=0000", req_ready); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL rstb_dropped got=%b want=0", wr_valid); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rstb_first_grant got=%b want=0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_decode_sweep();
    int p;
    req_valid = 4'b1000;
    for (int a = 0; a <= 32; a++) begin
      if (a < 32) set_req(3, 5'(a), 8'(a * 7 + 1), 1'b1);
      else req_valid = '0;
      #1;
      if (a < 32) begin
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL sweep_ready a=%0d got=%b want=1000", a, req_ready); end
      end
      if (a > 0) begin
        p = a - 1;
        total++; if (wr_reg_en !== 8'(1 << (p % 8)) || wr_byte_en !== 4'(1 << (p / 8))) begin
          bad++; $display("FAIL sweep_decode a=%0d got=%h/%h want=%h/%h", p, wr_reg_en, wr_byte_en, 8'(1 << (p % 8)), 4'(1 << (p / 8)));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit pend [4];
    int g;
    do_reset();
    for (int i = 0; i < 4; i++) pend[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          set_req(i, 5'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
        end
        req_valid[i] = pend[i];
      end
      wr_stall = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 79) == 0);
      #1;
      g = exp_grant();
      total++; if (req_ready !== exp_ready()) begin bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, req_ready, exp_ready()); end
      total++; if (wr_valid !== m_valid || wr_reg_en !== m_reg || wr_byte_en !== m_byte) begin
        bad++; $display("FAIL rand_stage c=%0d got=%b/%h/%h want=%b/%h/%h", c, wr_valid, wr_reg_en, wr_byte_en, m_valid, m_reg, m_byte);
      end
      total++; if (wr_data !== m_data || wr_src !== m_src) begin bad++; $display("FAIL rand_data c=%0d got=%h/%0d want=%h/%0d", c, wr_data, wr_src, m_data, m_src); end
      if (g >= 0) pend[g] = 0;
      tick();
    end
    rst = 1'b0;
    wr_stall = 1'b0;
    req_valid = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_addr = '0;
    req_data = '0;
    wr_stall = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_stall();
    test_burst_lock();
    test_reset_mid_burst();
    test_decode_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between 4 requesters issuing byte writes; round-robin arbitration, with optional burst locking.
- Request address is 5 bits: bits [2:0] select one of 8 registers, bits [4:3] select one of 4 byte lanes of the 32-bit register.
- Output is one registered write stage with valid/stall flow control, driving the register file's per-register write enables and per-byte lane enables directly.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4 in this revision because the pointer is 2 bits.
- BYTE_W, 8, request data width; the word is 4*BYTE_W.
- REG_CNT, 8, register count; fixed at 8 by the 3-bit register index.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  4  per-requester request valid.
- req_last  input  4  per-requester last beat of burst; 1 means a single write.
- req_addr  input  20  packed; requester i uses [5i+4:5i].
- req_data  input  32  packed; requester i uses [8i+7:8i].
- req_ready  output  4  per-requester grant/accept, combinational.
- wr_valid  output  1  write stage holds a pending write.
- wr_stall  input  1  register file cannot consume this cycle.
- wr_reg_en  output  8  one-hot register write enable; zero when wr_valid=0.
- wr_byte_en  output  4  one-hot byte-lane enable; zero when wr_valid=0.
- wr_data  output  32  request byte replicated to all 4 lanes.
- wr_src  output  2  index of the requester that owns the current write.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - wr_valid=0, wr_reg_en=0, wr_byte_en=0, wr_data=0, wr_src=0.
  - Round-robin pointer ptr=0; state=ARB; owner=0.
  - req_ready=0 during any cycle with rst=1.
- Accepting new writes:
  - can_accept = !wr_valid | !wr_stall.
  - No req_ready is asserted when can_accept=0.
- ARB state:
  - If can_accept, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - req_ready is one-hot or zero, and only ever asserted together with the matching req_valid.
- Transfer:
  - A transfer happens when req_valid[i] & req_ready[i].
  - On a transfer with req_last[i]=1: ptr <= (i+1) mod 4; state stays ARB.
  - On a transfer with req_last[i]=0: state <= LOCKED, owner <= i; ptr is unchanged.
- LOCKED state:
  - Only owner is eligible. Grant owner if req_valid[owner] & can_accept.
  - If owner is not valid, insert a bubble; other requesters wait, with no timeout.
  - A transfer with req_last=1 returns to ARB with ptr <= (owner+1) mod 4.
- Write stage (1-cycle latency): on a transfer at edge N, after edge N+1:
  - wr_valid=1, wr_src=i.
  - wr_reg_en = 1 << addr[2:0]; wr_byte_en = 1 << addr[4:3].
  - wr_data = {4{data}}.
- Stage update:
  - If wr_valid & wr_stall, all outputs hold unchanged.
  - If there is no transfer and the stage is not stalled: wr_valid, wr_reg_en and wr_byte_en go to 0; wr_data and wr_src retain their values.
  - Back-to-back transfers with wr_stall=0 give one write per cycle; throughput is 1 per cycle.
- Simultaneous events:
  - A stall release and a new grant in the same cycle are allowed: can_accept=1 because !wr_stall, and the stage reloads.
- Reset mid-operation:
  - rst during LOCKED aborts the burst: state=ARB, ptr=0, and the pending write is dropped (wr_valid=0).
  - Bytes already written by the burst are not rolled back.
- Requester obligations (checked by the bench, not by the block):
  - req_addr, req_data and req_last are stable while valid is high without ready.
  - valid is not withdrawn before ready.

Test Plan:
1. Reset then single write: rst 1 cycle; req_valid=0001, addr0=5'b10_011, data0=8'hA5, last=1 -> req_ready=0001 in the same cycle; next cycle wr_valid=1, wr_reg_en=8'h08, wr_byte_en=4'h4, wr_data=32'hA5A5A5A5, wr_src=0; following cycle wr_valid=0.
2. Round-robin fairness: req_valid=1111 held, all last=1, wr_stall=0 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, and wr_src follows the same order one cycle later.
3. Stall/backpressure: load a write, then wr_stall=1 for 3 cycles with req_valid=0010 -> req_ready=0 and outputs frozen for 3 cycles; in the cycle wr_stall drops, req_ready=0010 and the stage reloads the next cycle with no gap.
4. Burst lock: requester 2 sends 3 beats (last=0,0,1) while requesters 0 and 1 stay valid, and requester 2 drops valid for 1 cycle mid-burst -> only requester 2 is granted, with a 1-cycle bubble; after last, the next grant goes to requester 3 if valid, else requester 0.
5. Reset mid-burst: rst asserted after beat 1 of a locked burst from requester 1 -> next cycle wr_valid=0 and state=ARB; with req_valid=0011 the first grant is requester 0.
6. Decode sweep: all 32 addresses from one requester -> wr_reg_en and wr_byte_en match (1 << addr[2:0], 1 << addr[4:3]) exactly, one-hot every time.
